// File: rtl/seq_walker_p.sv
// rtl/seq_walker_p.sv - table-driven sequence walker with wrap/hold and mask-match flag
// Optional coverage outputs (z1_seen, hit_cyc) under `ifdef SEQ_WALKER_COVER_EN.
module seq_walker_p #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 8,
  parameter logic [W-1:0] MASK = W'(5),
  parameter int unsigned CNT_W = 8,
  localparam int unsigned IW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i1,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [W-1:0]     wr_data,
  input  logic             wr_last,
  output logic [W-1:0]     x,
  output logic [IW-1:0]    idx,
  output logic             z1,
  output logic             hold,
`ifdef SEQ_WALKER_COVER_EN
  output logic             z1_seen,
  output logic [15:0]      hit_cyc,
`endif
  output logic [CNT_W-1:0] wraps
);

  localparam logic [IW-1:0]    LAST_IDX = IW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [W-1:0]     val_q [DEPTH];
  logic [W-1:0]     val_d [DEPTH];
  logic [DEPTH-1:0] last_q, last_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             hold_q, hold_d;
  logic [CNT_W-1:0] wraps_q, wraps_d;

  assign x     = val_q[idx_q];
  assign z1    = ((x & MASK) == MASK);
  assign idx   = idx_q;
  assign hold  = hold_q;
  assign wraps = wraps_q;

  // Step decision reads pre-edge table; a same-cycle write lands alongside it.
  always_comb begin
    val_d   = val_q;
    last_d  = last_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    wraps_d = wraps_q;
    if (i1) begin
      if (last_q[idx_q]) begin
        idx_d  = '0;
        hold_d = 1'b0;
        if (wraps_q != CNT_MAX) begin
          wraps_d = wraps_q + 1'b1;
        end
      end else if (idx_q == LAST_IDX) begin
        hold_d = 1'b1;
      end else begin
        idx_d  = idx_q + 1'b1;
        hold_d = 1'b0;
      end
    end
    if (wr_en) begin
      val_d[wr_idx]  = wr_data;
      last_d[wr_idx] = wr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        val_q[i] <= '0;
      end
      last_q  <= '0;
      idx_q   <= '0;
      hold_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        val_q[i] <= val_d[i];
      end
      last_q  <= last_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      wraps_q <= wraps_d;
    end
  end

`ifdef SEQ_WALKER_COVER_EN
  logic        z1_seen_q, z1_seen_d;
  logic [15:0] hit_cyc_q, hit_cyc_d;

  assign z1_seen = z1_seen_q;
  assign hit_cyc = hit_cyc_q;

  // Cycle counter stops advancing once the property has been observed.
  always_comb begin
    z1_seen_d = z1_seen_q | z1;
    hit_cyc_d = hit_cyc_q;
    if (!z1_seen_q && hit_cyc_q != 16'hFFFF) begin
      hit_cyc_d = hit_cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z1_seen_q <= 1'b0;
      hit_cyc_q <= '0;
    end else begin
      z1_seen_q <= z1_seen_d;
      hit_cyc_q <= hit_cyc_d;
    end
  end
`endif

endmodule
